prediction_stat_table: RTL and testbench
========================================

PREDICTION_STAT_TABLE -- requirements
Module: prediction_stat_table

Interface
REQ-001 Parameter JUMP_STATUS_COUNTER_WIDTH, default 2, width of LHP/GHP jump-status counters used as table index.
REQ-002 Parameter STAT_COUNTER_WIDTH, default 5, width of signed two's-complement stat counters.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rd_addr  input  3  branch slot being predicted this cycle.
REQ-006 SP_prediction_result  input  1  static-predictor bit; SP read index.
REQ-007 LHP_count, GHP_count  input  JUMP_STATUS_COUNTER_WIDTH each  local/global counters; LHP/GHP read indices; MSB is predicted direction.
REQ-008 SP_stat_count, LHP_stat_count, GHP_stat_count  output  STAT_COUNTER_WIDTH each  stat count at (rd_addr, index).
REQ-009 SP_trend_count, LHP_trend_count, GHP_trend_count  output  3 each  trend count at (rd_addr, index).
REQ-010 sel  output  2  chosen predictor: 2'b00 SP, 2'b01 LHP, 2'b10 GHP; 2'b11 never driven.
REQ-011 final_prediction  output  1  direction of the chosen predictor.
REQ-012 clear_en1, clear_en2  input  1 each  clear stat counters of WR_addr1 / WR_addr2.
REQ-013 WR_{SP,LHP,GHP}_stat_en1/2, WR_{SP,LHP,GHP}_trend_en1/2  input  1 each  per-port, per-predictor write enables.
REQ-014 WR_addr1, WR_addr2  input  3 each  write slot per port.
REQ-015 WR_SP_index1/2 (1 bit), WR_LHP_index1/2, WR_GHP_index1/2 (JUMP_STATUS_COUNTER_WIDTH)  input  write index per port.
REQ-016 WR_{SP,LHP,GHP}_stat_count1/2 (STAT_COUNTER_WIDTH), WR_{SP,LHP,GHP}_trend_count1/2 (3)  input  write data per port.

Function
REQ-017 Storage: 8 slots; per slot 2 SP, 2^JUMP_STATUS_COUNTER_WIDTH LHP, 2^JUMP_STATUS_COUNTER_WIDTH GHP entries, each {stat, trend}.
REQ-018 Read path combinational from rd_addr and indices; zero latency; no write-to-read bypass (same-cycle write visible next cycle).
REQ-019 Writes take effect at posedge when enable high; stat and trend fields written independently.
REQ-020 Same entry written by both ports in one cycle: port 2 data wins, per field.
REQ-021 clear_enN: all stat counters (SP, LHP, GHP, all indices) of WR_addrN set to 0 at posedge; trend counters untouched.
REQ-022 Clear beats any stat write to the same slot in that cycle, from either port; trend writes still applied.
REQ-023 Both clears same cycle: both slots cleared (one slot if addresses equal).
REQ-024 Selection: highest signed stat count wins; tie -> higher signed trend count; still tied -> priority GHP > LHP > SP.
REQ-025 final_prediction = SP_prediction_result, LHP_count MSB or GHP_count MSB per sel.
REQ-026 Module does not saturate or add; it stores given data verbatim (arithmetic/overflow owned upstream).
REQ-027 No pipeline-stall input; enables are already qualified by the caller.

Reset
REQ-028 When rst_n low at posedge: every stat and trend field = 0; writes and clears ignored that cycle.
REQ-029 After reset: all stats 0, trends 0, so sel = 2'b10 (GHP) and final_prediction = GHP_count MSB.
REQ-030 Reset mid-write: reset wins; next cycle reads 0.

Structure
REQ-031 Shared package: predictor-select encodings (SEL_SP/SEL_LHP/SEL_GHP), slot count 8, address width 3, trend width 3.
REQ-032 One sub-module, predictor_selector: combinational 3-way signed compare of {stat, trend} with fixed priority, drives sel and final_prediction.
REQ-033 Storage as flops (no RAM macro); target 120-400 RTL lines.

Verification
REQ-034 Reset, rd_addr=5, GHP_count=2'b10 -> all counts 0, sel=2'b10, final_prediction=1.
REQ-035 Port1 writes LHP stat 5'd7, trend 3'd2 at (addr 3, idx 1); next cycle rd_addr=3, LHP_count=1 -> LHP_stat_count=7, sel=2'b01.
REQ-036 Both ports write SP stat (addr 2, idx 0): port1 5'd4, port2 5'd9 -> read returns 9.
REQ-037 Preload addr 6 stats SP=3, LHP=-2, GHP=5; clear_en2 with WR_addr2=6 plus port1 GHP stat write 5'd11 same cycle -> all stats 0, trends unchanged.
REQ-038 SP=LHP=GHP stat 4, trends SP=1, LHP=3, GHP=3 -> sel=2'b10; set GHP trend 2 -> sel=2'b01.
REQ-039 Write issued same cycle as read of same entry -> old value that cycle, new value next cycle.

Source files
------------

// File: rtl/prediction_stat_table_pkg.sv
// prediction_stat_table_pkg: shared encodings and sizes for the prediction stat table.
package prediction_stat_table_pkg;
    localparam int NUM_SLOTS = 8;
    localparam int ADDR_W = 3;
    localparam int TREND_W = 3;
    localparam logic [1:0] SEL_SP = 2'b00;
    localparam logic [1:0] SEL_LHP = 2'b01;
    localparam logic [1:0] SEL_GHP = 2'b10;
endpackage

// File: rtl/prediction_stat_table_selector.sv
// predictor_selector: picks the predictor with the best signed {stat, trend}, ties to GHP > LHP > SP.
module predictor_selector
    import prediction_stat_table_pkg::*;
#(
    parameter int STAT_W = 5
) (
    input  logic [STAT_W-1:0]  sp_stat,
    input  logic [STAT_W-1:0]  lhp_stat,
    input  logic [STAT_W-1:0]  ghp_stat,
    input  logic [TREND_W-1:0] sp_trend,
    input  logic [TREND_W-1:0] lhp_trend,
    input  logic [TREND_W-1:0] ghp_trend,
    input  logic               sp_dir,
    input  logic               lhp_dir,
    input  logic               ghp_dir,
    output logic [1:0]         sel,
    output logic               final_prediction
);
    function automatic logic beats(input logic signed [STAT_W-1:0] a_stat,
                                   input logic signed [TREND_W-1:0] a_trend,
                                   input logic signed [STAT_W-1:0] b_stat,
                                   input logic signed [TREND_W-1:0] b_trend);
        return (a_stat > b_stat) || (a_stat == b_stat && a_trend > b_trend);
    endfunction

    logic                lhp_over_ghp;
    logic                sp_over_best;
    logic [STAT_W-1:0]   best_stat;
    logic [TREND_W-1:0]  best_trend;

    // Only a strict win displaces the incumbent, which yields the GHP > LHP > SP tie order.
    always_comb begin
        lhp_over_ghp = beats(lhp_stat, lhp_trend, ghp_stat, ghp_trend);
        best_stat = lhp_over_ghp ? lhp_stat : ghp_stat;
        best_trend = lhp_over_ghp ? lhp_trend : ghp_trend;
        sp_over_best = beats(sp_stat, sp_trend, best_stat, best_trend);
        sel = sp_over_best ? SEL_SP : lhp_over_ghp ? SEL_LHP : SEL_GHP;
        final_prediction = sp_over_best ? sp_dir : lhp_over_ghp ? lhp_dir : ghp_dir;
    end
endmodule

// File: rtl/prediction_stat_table.sv
// prediction_stat_table: per-slot stat/trend storage for SP/LHP/GHP with two write ports and a best-predictor select.
module prediction_stat_table
    import prediction_stat_table_pkg::*;
#(
    parameter int JUMP_STATUS_COUNTER_WIDTH = 2,
    parameter int STAT_COUNTER_WIDTH = 5
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ADDR_W-1:0]                    rd_addr,
    input  logic                                 SP_prediction_result,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_count,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] GHP_count,
    output logic [STAT_COUNTER_WIDTH-1:0]        SP_stat_count,
    output logic [STAT_COUNTER_WIDTH-1:0]        LHP_stat_count,
    output logic [STAT_COUNTER_WIDTH-1:0]        GHP_stat_count,
    output logic [TREND_W-1:0]                   SP_trend_count,
    output logic [TREND_W-1:0]                   LHP_trend_count,
    output logic [TREND_W-1:0]                   GHP_trend_count,
    output logic [1:0]                           sel,
    output logic                                 final_prediction,
    input  logic                                 clear_en1,
    input  logic                                 clear_en2,
    input  logic                                 WR_SP_stat_en1,
    input  logic                                 WR_SP_stat_en2,
    input  logic                                 WR_LHP_stat_en1,
    input  logic                                 WR_LHP_stat_en2,
    input  logic                                 WR_GHP_stat_en1,
    input  logic                                 WR_GHP_stat_en2,
    input  logic                                 WR_SP_trend_en1,
    input  logic                                 WR_SP_trend_en2,
    input  logic                                 WR_LHP_trend_en1,
    input  logic                                 WR_LHP_trend_en2,
    input  logic                                 WR_GHP_trend_en1,
    input  logic                                 WR_GHP_trend_en2,
    input  logic [ADDR_W-1:0]                    WR_addr1,
    input  logic [ADDR_W-1:0]                    WR_addr2,
    input  logic                                 WR_SP_index1,
    input  logic                                 WR_SP_index2,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] WR_LHP_index1,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] WR_LHP_index2,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] WR_GHP_index1,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] WR_GHP_index2,
    input  logic [STAT_COUNTER_WIDTH-1:0]        WR_SP_stat_count1,
    input  logic [STAT_COUNTER_WIDTH-1:0]        WR_SP_stat_count2,
    input  logic [STAT_COUNTER_WIDTH-1:0]        WR_LHP_stat_count1,
    input  logic [STAT_COUNTER_WIDTH-1:0]        WR_LHP_stat_count2,
    input  logic [STAT_COUNTER_WIDTH-1:0]        WR_GHP_stat_count1,
    input  logic [STAT_COUNTER_WIDTH-1:0]        WR_GHP_stat_count2,
    input  logic [TREND_W-1:0]                   WR_SP_trend_count1,
    input  logic [TREND_W-1:0]                   WR_SP_trend_count2,
    input  logic [TREND_W-1:0]                   WR_LHP_trend_count1,
    input  logic [TREND_W-1:0]                   WR_LHP_trend_count2,
    input  logic [TREND_W-1:0]                   WR_GHP_trend_count1,
    input  logic [TREND_W-1:0]                   WR_GHP_trend_count2
);
    localparam int DEPTH = 1 << JUMP_STATUS_COUNTER_WIDTH;
    localparam int SW = STAT_COUNTER_WIDTH;

    logic [1:0][SW-1:0]            sp_stat   [NUM_SLOTS];
    logic [DEPTH-1:0][SW-1:0]      lhp_stat  [NUM_SLOTS];
    logic [DEPTH-1:0][SW-1:0]      ghp_stat  [NUM_SLOTS];
    logic [1:0][TREND_W-1:0]       sp_trend  [NUM_SLOTS];
    logic [DEPTH-1:0][TREND_W-1:0] lhp_trend [NUM_SLOTS];
    logic [DEPTH-1:0][TREND_W-1:0] ghp_trend [NUM_SLOTS];

    // Later statements win: port 2 overrides port 1, and clears override any stat write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_stat <= '{default: '0};
            lhp_stat <= '{default: '0};
            ghp_stat <= '{default: '0};
            sp_trend <= '{default: '0};
            lhp_trend <= '{default: '0};
            ghp_trend <= '{default: '0};
        end else begin
            if (WR_SP_stat_en1) sp_stat[WR_addr1][WR_SP_index1] <= WR_SP_stat_count1;
            if (WR_LHP_stat_en1) lhp_stat[WR_addr1][WR_LHP_index1] <= WR_LHP_stat_count1;
            if (WR_GHP_stat_en1) ghp_stat[WR_addr1][WR_GHP_index1] <= WR_GHP_stat_count1;
            if (WR_SP_trend_en1) sp_trend[WR_addr1][WR_SP_index1] <= WR_SP_trend_count1;
            if (WR_LHP_trend_en1) lhp_trend[WR_addr1][WR_LHP_index1] <= WR_LHP_trend_count1;
            if (WR_GHP_trend_en1) ghp_trend[WR_addr1][WR_GHP_index1] <= WR_GHP_trend_count1;
            if (WR_SP_stat_en2) sp_stat[WR_addr2][WR_SP_index2] <= WR_SP_stat_count2;
            if (WR_LHP_stat_en2) lhp_stat[WR_addr2][WR_LHP_index2] <= WR_LHP_stat_count2;
            if (WR_GHP_stat_en2) ghp_stat[WR_addr2][WR_GHP_index2] <= WR_GHP_stat_count2;
            if (WR_SP_trend_en2) sp_trend[WR_addr2][WR_SP_index2] <= WR_SP_trend_count2;
            if (WR_LHP_trend_en2) lhp_trend[WR_addr2][WR_LHP_index2] <= WR_LHP_trend_count2;
            if (WR_GHP_trend_en2) ghp_trend[WR_addr2][WR_GHP_index2] <= WR_GHP_trend_count2;
            if (clear_en1) begin
                sp_stat[WR_addr1] <= '0;
                lhp_stat[WR_addr1] <= '0;
                ghp_stat[WR_addr1] <= '0;
            end
            if (clear_en2) begin
                sp_stat[WR_addr2] <= '0;
                lhp_stat[WR_addr2] <= '0;
                ghp_stat[WR_addr2] <= '0;
            end
        end
    end

    assign SP_stat_count = sp_stat[rd_addr][SP_prediction_result];
    assign LHP_stat_count = lhp_stat[rd_addr][LHP_count];
    assign GHP_stat_count = ghp_stat[rd_addr][GHP_count];
    assign SP_trend_count = sp_trend[rd_addr][SP_prediction_result];
    assign LHP_trend_count = lhp_trend[rd_addr][LHP_count];
    assign GHP_trend_count = ghp_trend[rd_addr][GHP_count];

    predictor_selector #(.STAT_W(SW)) u_selector (
        .sp_stat          (SP_stat_count),
        .lhp_stat         (LHP_stat_count),
        .ghp_stat         (GHP_stat_count),
        .sp_trend         (SP_trend_count),
        .lhp_trend        (LHP_trend_count),
        .ghp_trend        (GHP_trend_count),
        .sp_dir           (SP_prediction_result),
        .lhp_dir          (LHP_count[JUMP_STATUS_COUNTER_WIDTH-1]),
        .ghp_dir          (GHP_count[JUMP_STATUS_COUNTER_WIDTH-1]),
        .sel              (sel),
        .final_prediction (final_prediction)
    );
endmodule

// File: tb/tb_prediction_stat_table.sv
// tb_prediction_stat_table: directed and random checks of prediction_stat_table against an array model.
module tb_prediction_stat_table;
    localparam int J = 2;
    localparam int S = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] rd_addr;
    logic SP_prediction_result;
    logic [J-1:0] LHP_count, GHP_count;
    logic [S-1:0] SP_stat_count, LHP_stat_count, GHP_stat_count;
    logic [2:0] SP_trend_count, LHP_trend_count, GHP_trend_count;
    logic [1:0] sel;
    logic final_prediction;
    logic clear_en1, clear_en2;
    logic WR_SP_stat_en1, WR_SP_stat_en2, WR_LHP_stat_en1, WR_LHP_stat_en2, WR_GHP_stat_en1, WR_GHP_stat_en2;
    logic WR_SP_trend_en1, WR_SP_trend_en2, WR_LHP_trend_en1, WR_LHP_trend_en2, WR_GHP_trend_en1, WR_GHP_trend_en2;
    logic [2:0] WR_addr1, WR_addr2;
    logic WR_SP_index1, WR_SP_index2;
    logic [J-1:0] WR_LHP_index1, WR_LHP_index2, WR_GHP_index1, WR_GHP_index2;
    logic [S-1:0] WR_SP_stat_count1, WR_SP_stat_count2, WR_LHP_stat_count1, WR_LHP_stat_count2;
    logic [S-1:0] WR_GHP_stat_count1, WR_GHP_stat_count2;
    logic [2:0] WR_SP_trend_count1, WR_SP_trend_count2, WR_LHP_trend_count1, WR_LHP_trend_count2;
    logic [2:0] WR_GHP_trend_count1, WR_GHP_trend_count2;

    prediction_stat_table #(.JUMP_STATUS_COUNTER_WIDTH(J), .STAT_COUNTER_WIDTH(S)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .SP_prediction_result(SP_prediction_result),
        .LHP_count(LHP_count), .GHP_count(GHP_count),
        .SP_stat_count(SP_stat_count), .LHP_stat_count(LHP_stat_count), .GHP_stat_count(GHP_stat_count),
        .SP_trend_count(SP_trend_count), .LHP_trend_count(LHP_trend_count), .GHP_trend_count(GHP_trend_count),
        .sel(sel), .final_prediction(final_prediction), .clear_en1(clear_en1), .clear_en2(clear_en2),
        .WR_SP_stat_en1(WR_SP_stat_en1), .WR_SP_stat_en2(WR_SP_stat_en2),
        .WR_LHP_stat_en1(WR_LHP_stat_en1), .WR_LHP_stat_en2(WR_LHP_stat_en2),
        .WR_GHP_stat_en1(WR_GHP_stat_en1), .WR_GHP_stat_en2(WR_GHP_stat_en2),
        .WR_SP_trend_en1(WR_SP_trend_en1), .WR_SP_trend_en2(WR_SP_trend_en2),
        .WR_LHP_trend_en1(WR_LHP_trend_en1), .WR_LHP_trend_en2(WR_LHP_trend_en2),
        .WR_GHP_trend_en1(WR_GHP_trend_en1), .WR_GHP_trend_en2(WR_GHP_trend_en2),
        .WR_addr1(WR_addr1), .WR_addr2(WR_addr2),
        .WR_SP_index1(WR_SP_index1), .WR_SP_index2(WR_SP_index2),
        .WR_LHP_index1(WR_LHP_index1), .WR_LHP_index2(WR_LHP_index2),
        .WR_GHP_index1(WR_GHP_index1), .WR_GHP_index2(WR_GHP_index2),
        .WR_SP_stat_count1(WR_SP_stat_count1), .WR_SP_stat_count2(WR_SP_stat_count2),
        .WR_LHP_stat_count1(WR_LHP_stat_count1), .WR_LHP_stat_count2(WR_LHP_stat_count2),
        .WR_GHP_stat_count1(WR_GHP_stat_count1), .WR_GHP_stat_count2(WR_GHP_stat_count2),
        .WR_SP_trend_count1(WR_SP_trend_count1), .WR_SP_trend_count2(WR_SP_trend_count2),
        .WR_LHP_trend_count1(WR_LHP_trend_count1), .WR_LHP_trend_count2(WR_LHP_trend_count2),
        .WR_GHP_trend_count1(WR_GHP_trend_count1), .WR_GHP_trend_count2(WR_GHP_trend_count2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int m_sp_s[8][2], m_sp_t[8][2];
    int m_lhp_s[8][4], m_lhp_t[8][4], m_ghp_s[8][4], m_ghp_t[8][4];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic int sx(input int v, input int w);
        int m = v & ((1 << w) - 1);
        return m >= (1 << (w - 1)) ? m - (1 << w) : m;
    endfunction

    // Model follows the written rules: port 1, then port 2 overrides, then clears zero stats.
    task automatic model_update();
        if (!rst_n) begin
            for (int a = 0; a < 8; a++) begin
                for (int i = 0; i < 2; i++) begin m_sp_s[a][i] = 0; m_sp_t[a][i] = 0; end
                for (int i = 0; i < 4; i++) begin
                    m_lhp_s[a][i] = 0; m_lhp_t[a][i] = 0; m_ghp_s[a][i] = 0; m_ghp_t[a][i] = 0;
                end
            end
            return;
        end
        if (WR_SP_stat_en1) m_sp_s[WR_addr1][WR_SP_index1] = sx(int'(WR_SP_stat_count1), S);
        if (WR_LHP_stat_en1) m_lhp_s[WR_addr1][WR_LHP_index1] = sx(int'(WR_LHP_stat_count1), S);
        if (WR_GHP_stat_en1) m_ghp_s[WR_addr1][WR_GHP_index1] = sx(int'(WR_GHP_stat_count1), S);
        if (WR_SP_trend_en1) m_sp_t[WR_addr1][WR_SP_index1] = sx(int'(WR_SP_trend_count1), 3);
        if (WR_LHP_trend_en1) m_lhp_t[WR_addr1][WR_LHP_index1] = sx(int'(WR_LHP_trend_count1), 3);
        if (WR_GHP_trend_en1) m_ghp_t[WR_addr1][WR_GHP_index1] = sx(int'(WR_GHP_trend_count1), 3);
        if (WR_SP_stat_en2) m_sp_s[WR_addr2][WR_SP_index2] = sx(int'(WR_SP_stat_count2), S);
        if (WR_LHP_stat_en2) m_lhp_s[WR_addr2][WR_LHP_index2] = sx(int'(WR_LHP_stat_count2), S);
        if (WR_GHP_stat_en2) m_ghp_s[WR_addr2][WR_GHP_index2] = sx(int'(WR_GHP_stat_count2), S);
        if (WR_SP_trend_en2) m_sp_t[WR_addr2][WR_SP_index2] = sx(int'(WR_SP_trend_count2), 3);
        if (WR_LHP_trend_en2) m_lhp_t[WR_addr2][WR_LHP_index2] = sx(int'(WR_LHP_trend_count2), 3);
        if (WR_GHP_trend_en2) m_ghp_t[WR_addr2][WR_GHP_index2] = sx(int'(WR_GHP_trend_count2), 3);
        for (int i = 0; i < 4; i++) begin
            if (clear_en1) begin
                if (i < 2) m_sp_s[WR_addr1][i] = 0;
                m_lhp_s[WR_addr1][i] = 0; m_ghp_s[WR_addr1][i] = 0;
            end
            if (clear_en2) begin
                if (i < 2) m_sp_s[WR_addr2][i] = 0;
                m_lhp_s[WR_addr2][i] = 0; m_ghp_s[WR_addr2][i] = 0;
            end
        end
    endtask

    // Rank each predictor by one integer key: stat dominates, then trend, then fixed priority.
    task automatic check_outputs();
        int ss, ls, gs, st, lt, gt, k_sp, k_lhp, k_ghp, e_sel, e_dir;
        ss = m_sp_s[rd_addr][SP_prediction_result]; st = m_sp_t[rd_addr][SP_prediction_result];
        ls = m_lhp_s[rd_addr][LHP_count]; lt = m_lhp_t[rd_addr][LHP_count];
        gs = m_ghp_s[rd_addr][GHP_count]; gt = m_ghp_t[rd_addr][GHP_count];
        k_sp = ss * 32 + (st + 4) * 4 + 0;
        k_lhp = ls * 32 + (lt + 4) * 4 + 1;
        k_ghp = gs * 32 + (gt + 4) * 4 + 2;
        if (k_ghp > k_lhp && k_ghp > k_sp) begin e_sel = 2; e_dir = int'(GHP_count[J-1]); end
        else if (k_lhp > k_sp) begin e_sel = 1; e_dir = int'(LHP_count[J-1]); end
        else begin e_sel = 0; e_dir = int'(SP_prediction_result); end
        check("sp_stat", sx(int'(SP_stat_count), S), ss);
        check("lhp_stat", sx(int'(LHP_stat_count), S), ls);
        check("ghp_stat", sx(int'(GHP_stat_count), S), gs);
        check("sp_trend", sx(int'(SP_trend_count), 3), st);
        check("lhp_trend", sx(int'(LHP_trend_count), 3), lt);
        check("ghp_trend", sx(int'(GHP_trend_count), 3), gt);
        check("sel", int'(sel), e_sel);
        check("final_prediction", int'(final_prediction), e_dir);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        {clear_en1, clear_en2} = '0;
        {WR_SP_stat_en1, WR_SP_stat_en2, WR_LHP_stat_en1, WR_LHP_stat_en2, WR_GHP_stat_en1, WR_GHP_stat_en2} = '0;
        {WR_SP_trend_en1, WR_SP_trend_en2, WR_LHP_trend_en1, WR_LHP_trend_en2, WR_GHP_trend_en1, WR_GHP_trend_en2} = '0;
        {WR_addr1, WR_addr2, WR_SP_index1, WR_SP_index2} = '0;
        {WR_LHP_index1, WR_LHP_index2, WR_GHP_index1, WR_GHP_index2} = '0;
        {WR_SP_stat_count1, WR_SP_stat_count2, WR_LHP_stat_count1, WR_LHP_stat_count2} = '0;
        {WR_GHP_stat_count1, WR_GHP_stat_count2} = '0;
        {WR_SP_trend_count1, WR_SP_trend_count2, WR_LHP_trend_count1, WR_LHP_trend_count2} = '0;
        {WR_GHP_trend_count1, WR_GHP_trend_count2} = '0;
    endtask

    function automatic logic [S-1:0] rstat();
        return $urandom_range(0, 1) ? S'($urandom_range(0, 31)) : S'($urandom_range(3, 5));
    endfunction

    task automatic randomize_inputs();
        rst_n = ($urandom_range(0, 49) != 0);
        rd_addr = 3'($urandom_range(0, 7));
        SP_prediction_result = 1'($urandom_range(0, 1));
        LHP_count = J'($urandom_range(0, 3)); GHP_count = J'($urandom_range(0, 3));
        clear_en1 = ($urandom_range(0, 7) == 0); clear_en2 = ($urandom_range(0, 7) == 0);
        {WR_SP_stat_en1, WR_SP_stat_en2, WR_LHP_stat_en1, WR_LHP_stat_en2, WR_GHP_stat_en1, WR_GHP_stat_en2} = 6'($urandom);
        {WR_SP_trend_en1, WR_SP_trend_en2, WR_LHP_trend_en1, WR_LHP_trend_en2, WR_GHP_trend_en1, WR_GHP_trend_en2} = 6'($urandom);
        WR_addr1 = 3'($urandom_range(0, 7));
        WR_addr2 = $urandom_range(0, 2) == 0 ? WR_addr1 : 3'($urandom_range(0, 7));
        WR_SP_index1 = 1'($urandom_range(0, 1)); WR_SP_index2 = 1'($urandom_range(0, 1));
        WR_LHP_index1 = J'($urandom_range(0, 3)); WR_LHP_index2 = J'($urandom_range(0, 3));
        WR_GHP_index1 = J'($urandom_range(0, 3)); WR_GHP_index2 = J'($urandom_range(0, 3));
        WR_SP_stat_count1 = rstat(); WR_SP_stat_count2 = rstat();
        WR_LHP_stat_count1 = rstat(); WR_LHP_stat_count2 = rstat();
        WR_GHP_stat_count1 = rstat(); WR_GHP_stat_count2 = rstat();
        {WR_SP_trend_count1, WR_SP_trend_count2, WR_LHP_trend_count1} = 9'($urandom);
        {WR_LHP_trend_count2, WR_GHP_trend_count1, WR_GHP_trend_count2} = 9'($urandom);
    endtask

    initial begin
        idle();
        rst_n = 1'b0; rd_addr = 3'd5; SP_prediction_result = 1'b0; LHP_count = '0; GHP_count = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_sel", int'(sel), 2);
        check("rst_final", int'(final_prediction), 1);
        check("rst_ghp_stat", int'(GHP_stat_count), 0);
        cycle();
        WR_LHP_stat_en1 = 1'b1; WR_LHP_trend_en1 = 1'b1; WR_addr1 = 3'd3; WR_LHP_index1 = 2'd1;
        WR_LHP_stat_count1 = 5'd7; WR_LHP_trend_count1 = 3'd2;
        cycle();
        idle();
        rd_addr = 3'd3; LHP_count = 2'd1; GHP_count = 2'd0;
        #1;
        check("lhp_write_stat", int'(LHP_stat_count), 7);
        check("lhp_write_sel", int'(sel), 1);
        cycle();
        WR_SP_stat_en1 = 1'b1; WR_SP_stat_en2 = 1'b1; WR_addr1 = 3'd2; WR_addr2 = 3'd2;
        WR_SP_stat_count1 = 5'd4; WR_SP_stat_count2 = 5'd9;
        cycle();
        idle();
        rd_addr = 3'd2; SP_prediction_result = 1'b0;
        #1;
        check("port2_wins", int'(SP_stat_count), 9);
        cycle();
        WR_addr1 = 3'd6; WR_addr2 = 3'd6;
        WR_SP_stat_en1 = 1'b1; WR_SP_stat_count1 = 5'd3; WR_SP_trend_en1 = 1'b1; WR_SP_trend_count1 = 3'd2;
        WR_LHP_stat_en2 = 1'b1; WR_LHP_stat_count2 = 5'b11110; WR_LHP_trend_en2 = 1'b1; WR_LHP_trend_count2 = 3'd1;
        cycle();
        idle();
        WR_addr1 = 3'd6; WR_GHP_stat_en1 = 1'b1; WR_GHP_stat_count1 = 5'd5;
        WR_GHP_trend_en1 = 1'b1; WR_GHP_trend_count1 = 3'd3;
        cycle();
        idle();
        clear_en2 = 1'b1; WR_addr2 = 3'd6; WR_addr1 = 3'd6; WR_GHP_stat_en1 = 1'b1; WR_GHP_stat_count1 = 5'd11;
        rd_addr = 3'd6; SP_prediction_result = 1'b0; LHP_count = '0; GHP_count = '0;
        #1;
        check("preload_lhp", sx(int'(LHP_stat_count), S), -2);
        cycle();
        idle();
        #1;
        check("clear_sp", int'(SP_stat_count), 0);
        check("clear_lhp", int'(LHP_stat_count), 0);
        check("clear_ghp", int'(GHP_stat_count), 0);
        check("clear_keeps_sp_trend", int'(SP_trend_count), 2);
        check("clear_keeps_ghp_trend", int'(GHP_trend_count), 3);
        WR_addr1 = 3'd1; WR_addr2 = 3'd1;
        WR_SP_stat_en1 = 1'b1; WR_SP_stat_count1 = 5'd4; WR_SP_trend_en1 = 1'b1; WR_SP_trend_count1 = 3'd1;
        WR_LHP_stat_en2 = 1'b1; WR_LHP_stat_count2 = 5'd4; WR_LHP_trend_en2 = 1'b1; WR_LHP_trend_count2 = 3'd3;
        cycle();
        idle();
        WR_addr1 = 3'd1; WR_GHP_stat_en1 = 1'b1; WR_GHP_stat_count1 = 5'd4;
        WR_GHP_trend_en1 = 1'b1; WR_GHP_trend_count1 = 3'd3;
        cycle();
        idle();
        rd_addr = 3'd1;
        #1;
        check("tie_to_ghp", int'(sel), 2);
        WR_addr1 = 3'd1; WR_GHP_trend_en1 = 1'b1; WR_GHP_trend_count1 = 3'd2;
        cycle();
        idle();
        #1;
        check("trend_to_lhp", int'(sel), 1);
        WR_addr1 = 3'd1; WR_SP_stat_en1 = 1'b1; WR_SP_stat_count1 = 5'd7;
        #1;
        check("same_cycle_old", int'(SP_stat_count), 4);
        cycle();
        idle();
        #1;
        check("next_cycle_new", int'(SP_stat_count), 7);
        rst_n = 1'b0; WR_addr1 = 3'd0; WR_LHP_stat_en1 = 1'b1; WR_LHP_index1 = 2'd2; WR_LHP_stat_count1 = 5'd9;
        cycle();
        idle();
        rst_n = 1'b1; rd_addr = 3'd0; LHP_count = 2'd2;
        #1;
        check("reset_beats_write", int'(LHP_stat_count), 0);
        for (int n = 0; n < 600; n++) begin
            randomize_inputs();
            cycle();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
